// File: rtl/aclk_pkg.sv
// Shared types and defaults for the alarm-clock controller.
// The optional entry timeout is enabled by the ACLK_TIMEOUT_EN macro.
package aclk_pkg;

  localparam logic [3:0] NOKEY_DEFAULT        = 4'd10;
  localparam int         TIMEOUT_SECS_DEFAULT = 10;
  localparam int         TIMER_WIDTH          = $clog2(TIMEOUT_SECS_DEFAULT + 1);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } aclk_state_e;

endpackage

// File: rtl/aclk_entry_timer.sv
// Inactivity timer for key entry: counts one_second pulses while enabled,
// saturating at TIMEOUT_SECS. Only instantiated when ACLK_TIMEOUT_EN is defined.
module aclk_entry_timer
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SECS = TIMEOUT_SECS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic timeout
);

  localparam int         W     = $clog2(TIMEOUT_SECS + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_SECS);

  logic [W-1:0] count;

  // Clear wins over counting so a fresh digit always restarts the window.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && one_second && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign timeout = (count == LIMIT);

endmodule

// File: rtl/aclk_controller.sv
// Moore sequencer for the alarm-clock datapath: key entry, load strobes and display select.
// Define ACLK_TIMEOUT_EN to abandon a stalled key entry after TIMEOUT_SECS seconds.
module aclk_controller
  import aclk_pkg::*;
#(
  parameter logic [3:0] NOKEY        = NOKEY_DEFAULT,
  parameter int         TIMEOUT_SECS = TIMEOUT_SECS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a
);

  aclk_state_e state, state_next;
  logic        timeout;
  logic        key_pressed;

  assign key_pressed = (key != NOKEY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW_TIME;
    end else begin
      state <= state_next;
    end
  end

  // Buttons take priority over key presses, which take priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)     state_next = SHOW_ALARM;
        else if (key_pressed) state_next = KEY_STORED;
      end
      KEY_STORED:
        state_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed)     state_next = KEY_ENTRY;
        else if (timeout)     state_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_next = SET_ALARM_TIME;
        else if (time_button) state_next = SET_CURRENT_TIME;
        else if (key_pressed) state_next = KEY_STORED;
        else if (timeout)     state_next = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button)    state_next = SHOW_TIME;
      end
      SET_ALARM_TIME:
        state_next = SHOW_TIME;
      SET_CURRENT_TIME:
        state_next = SHOW_TIME;
      default:
        state_next = SHOW_TIME;
    endcase
  end

  always_comb begin
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    shift         = 1'b0;
    show_new_time = 1'b0;
    show_a        = 1'b0;
    case (state)
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED, KEY_ENTRY:
        show_new_time = 1'b1;
      SHOW_ALARM:
        show_a = 1'b1;
      SET_ALARM_TIME:
        load_new_a = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ACLK_TIMEOUT_EN
  logic in_window;
  logic timer_clear;

  // Moving into KEY_STORED restarts the count even from inside the window.
  assign in_window   = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign timer_clear = !in_window || (state_next == KEY_STORED);

  aclk_entry_timer #(
    .TIMEOUT_SECS(TIMEOUT_SECS)
  ) u_entry_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .enable    (in_window),
    .one_second(one_second),
    .timeout   (timeout)
  );
`else
  logic unused_one_second;

  assign unused_one_second = one_second;
  assign timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_aclk_controller.sv
// Self-checking bench for aclk_controller: directed key/button sequences checked
// every cycle against a mode-level behavioural model plus literal expectations.
module tb_aclk_controller;

  localparam logic [3:0] NOKEY = 4'd10;
  localparam int         TSECS = 10;
`ifdef ACLK_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_ALARM = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = NOKEY;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       load_new_a, load_new_c, reset_count, shift, show_new_time, show_a;

  int checks = 0;
  int errors = 0;

  int n_shift, n_load_a, n_load_c, n_reset_count, n_snt_low;

  // Model: what the user is doing, not which FSM state the DUT is in.
  int m_mode   = M_IDLE;
  bit m_shift  = 1'b0;
  bit m_wait   = 1'b0;
  int m_load   = 0;
  int m_secs   = 0;
  bit m_valid  = 1'b0;

  aclk_controller #(
    .NOKEY       (NOKEY),
    .TIMEOUT_SECS(TSECS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .reset_count  (reset_count),
    .shift        (shift),
    .show_new_time(show_new_time),
    .show_a       (show_a)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic a, input logic t,
                               input logic s, input logic r, input int n);
    key = k;
    alarm_button = a;
    time_button = t;
    one_second = s;
    reset = r;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic enterDigit(input logic [3:0] d);
    applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic pulseSecond();
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 2);
  endtask

  task automatic clearCounts();
    n_shift = 0;
    n_load_a = 0;
    n_load_c = 0;
    n_reset_count = 0;
    n_snt_low = 0;
  endtask

  // Behavioural model advanced on each active edge.
  always @(posedge clk) begin
    bit tmo;
    bit in_window;
    if (reset) begin
      m_mode = M_IDLE; m_shift = 0; m_wait = 0; m_load = 0; m_secs = 0; m_valid = 1;
    end else if (m_valid) begin
      tmo       = TIMEOUT_ON && (m_secs == TSECS);
      in_window = (m_mode == M_ENTRY) && !m_shift && (m_load == 0);
      if (m_load != 0) begin
        m_load = 0;
      end else if (m_mode == M_IDLE) begin
        if (alarm_button) m_mode = M_ALARM;
        else if (key != NOKEY) begin m_mode = M_ENTRY; m_shift = 1; m_wait = 1; end
      end else if (m_mode == M_ALARM) begin
        if (!alarm_button) m_mode = M_IDLE;
      end else if (m_shift) begin
        m_shift = 0;
      end else if (m_wait) begin
        if (key == NOKEY) m_wait = 0;
        else if (tmo) m_mode = M_IDLE;
      end else if (alarm_button) begin
        m_load = 1; m_mode = M_IDLE;
      end else if (time_button) begin
        m_load = 2; m_mode = M_IDLE;
      end else if (key != NOKEY) begin
        m_shift = 1; m_wait = 1;
      end else if (tmo) begin
        m_mode = M_IDLE;
      end
      if (!in_window || m_shift) m_secs = 0;
      else if (one_second && m_secs < TSECS) m_secs++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("shift",         shift,         m_shift);
      checkOutput("show_new_time", show_new_time, (m_mode == M_ENTRY));
      checkOutput("show_a",        show_a,        (m_mode == M_ALARM));
      checkOutput("load_new_a",    load_new_a,    (m_load == 1));
      checkOutput("load_new_c",    load_new_c,    (m_load == 2));
      checkOutput("reset_count",   reset_count,   (m_load == 2));
      if (shift === 1'b1) n_shift++;
      if (load_new_a === 1'b1) n_load_a++;
      if (load_new_c === 1'b1) n_load_c++;
      if (reset_count === 1'b1) n_reset_count++;
      if (n_shift > 0 && show_new_time !== 1'b1) n_snt_low++;
    end
  end

  initial begin
    clearCounts();
    @(posedge clk);
    #2;
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    checkOutput("reset_outputs",
                {load_new_a, load_new_c, reset_count, shift, show_new_time, show_a}, 6'b0);

    // Reset in the middle of an entry
    clearCounts();
    applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("midentry_show_new_time", show_new_time, 1'b1);
    applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("midentry_reset_outputs",
                {load_new_a, load_new_c, reset_count, shift, show_new_time, show_a}, 6'b0);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("midentry_no_loads", n_load_a + n_load_c, 0);

    // Digits 1..4
    clearCounts();
    for (int d = 1; d <= 4; d++) enterDigit(4'(d));
    checkOutput("entry_shift_count", n_shift, 4);
    checkOutput("entry_snt_gaps", n_snt_low, 0);
    checkOutput("entry_show_new_time", show_new_time, 1'b1);

    // Set current time, then keep holding TIME
    clearCounts();
    applyStimulus(NOKEY, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("settime_load_new_c", load_new_c, 1'b1);
    checkOutput("settime_reset_count", reset_count, 1'b1);
    checkOutput("settime_load_new_a", load_new_a, 1'b0);
    applyStimulus(NOKEY, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    checkOutput("settime_load_c_count", n_load_c, 1);
    checkOutput("settime_reset_count_count", n_reset_count, 1);
    checkOutput("settime_back_to_time", show_new_time, 1'b0);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Set alarm with both buttons pressed together
    enterDigit(4'd0);
    enterDigit(4'd7);
    enterDigit(4'd3);
    enterDigit(4'd0);
    clearCounts();
    applyStimulus(NOKEY, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("setalarm_load_new_a", load_new_a, 1'b1);
    checkOutput("setalarm_load_new_c", load_new_c, 1'b0);
    applyStimulus(NOKEY, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("setalarm_show_a_held", show_a, 1'b1);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("setalarm_show_a_released", show_a, 1'b0);
    checkOutput("setalarm_load_a_count", n_load_a, 1);
    checkOutput("setalarm_load_c_count", n_load_c, 0);

    // Inactivity timeout, with a restart from a fresh digit after 9 seconds
    clearCounts();
    enterDigit(4'd5);
    repeat (9) pulseSecond();
    checkOutput("timeout_before_restart", show_new_time, 1'b1);
    applyStimulus(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    repeat (9) pulseSecond();
    checkOutput("timeout_nine_after_restart", show_new_time, 1'b1);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("timeout_tenth_counted", show_new_time, 1'b1);
    applyStimulus(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("timeout_exit", show_new_time, TIMEOUT_ON ? 1'b0 : 1'b1);
    repeat (20) pulseSecond();
    checkOutput("timeout_after_30", show_new_time, TIMEOUT_ON ? 1'b0 : 1'b1);
    checkOutput("timeout_no_loads", n_load_a + n_load_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aclk_controller.md
# aclk_controller

Moore state machine that sequences the alarm-clock datapath: it interprets keypad digits and the ALARM/TIME buttons, drives the shift register that accumulates entered digits, and issues single-cycle load strobes for the alarm and current-time registers. It also pulses `reset_count` to realign the time generator's second/minute divider whenever a new current time is loaded. An optional inactivity timeout abandons a stalled key entry.

## Interface
Parameters:
- `NOKEY`, 4'd10: keypad code meaning "no key pressed"; codes 0–9 are digits.
- `TIMEOUT_SECS`, 10: `one_second` pulses without key activity before entry is abandoned; legal range 1–15.

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: synchronous, active-high reset.
- `one_second` input 1: one-cycle pulse from the time generator.
- `key` input 4: current keypad code, already synchronised and held while the key is pressed.
- `alarm_button` input 1: level, high while ALARM is held.
- `time_button` input 1: level, high while TIME is held.
- `load_new_a` output 1: one-cycle strobe that loads the entry buffer into the alarm register.
- `load_new_c` output 1: one-cycle strobe that loads the entry buffer into the current-time counter.
- `reset_count` output 1: one-cycle strobe, coincident with `load_new_c`, that clears the time-generator divider.
- `shift` output 1: one-cycle strobe that shifts `key` into the entry buffer.
- `show_new_time` output 1: display selects the entry buffer.
- `show_a` output 1: display selects the alarm time.

## Operation
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
- SHOW_TIME:
  - `alarm_button` → SHOW_ALARM.
  - Otherwise, `key != NOKEY` → KEY_STORED.
  - Otherwise stay.
- KEY_STORED: `shift`=1; unconditionally → KEY_WAITED.
- KEY_WAITED (waiting for key release):
  - `key == NOKEY` → KEY_ENTRY.
  - Otherwise, timeout → SHOW_TIME.
  - Otherwise stay.
- KEY_ENTRY, priority order:
  - `alarm_button` → SET_ALARM_TIME.
  - `time_button` → SET_CURRENT_TIME.
  - `key != NOKEY` → KEY_STORED.
  - timeout → SHOW_TIME.
  - Otherwise stay.
- SHOW_ALARM: `show_a`=1; `alarm_button` low → SHOW_TIME, else stay.
- SET_ALARM_TIME: `load_new_a`=1; → SHOW_TIME.
- SET_CURRENT_TIME: `load_new_c`=1 and `reset_count`=1; → SHOW_TIME.
- `show_new_time`=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY; 0 elsewhere.
- All outputs are decoded from the state register only. No input-to-output combinational path.
- Simultaneous events:
  - Both buttons high in KEY_ENTRY: alarm wins.
  - Button and timeout in the same cycle: button wins.
  - `time_button` in SHOW_TIME: ignored.
- An undefined state encoding recovers to SHOW_TIME on the next edge.
- The entry buffer width and digit count are not checked here. Extra digits simply shift through the buffer.

## Timing
- Reset: state = SHOW_TIME, timeout counter = 0, so every output is 0 in the cycle after `reset` is sampled high.
- `reset` held high overrides all inputs. Reset in mid-entry discards the entry and issues no load strobe.
- Key press seen at edge N: KEY_STORED from N+1, so `shift` is high exactly one cycle.
- Latency from a button sampled in KEY_ENTRY at edge N to its load strobe: one cycle (strobe high N+1 to N+2).
- Timeout counter (when compiled in):
  - Clears in every state outside KEY_WAITED/KEY_ENTRY, and on entry to KEY_STORED.
  - Increments on each `one_second` pulse while in KEY_WAITED/KEY_ENTRY.
  - Saturates at `TIMEOUT_SECS`.
  - Timeout = counter == `TIMEOUT_SECS`, evaluated on the registered count, so the exit occurs the cycle after the final pulse is counted.

## Configuration
- `ACLK_TIMEOUT_EN` defined: timeout counter and timeout transitions are present as described.
- Undefined:
  - Counter logic is removed.
  - KEY_WAITED and KEY_ENTRY wait indefinitely; `one_second` is unused.
  - All other behaviour is identical.

## Structure
- Package `aclk_pkg` holds:
  - The state enum type.
  - `NOKEY` default.
  - `TIMEOUT_SECS` default.
  - The counter width constant (`$clog2(TIMEOUT_SECS+1)`).
- One sub-module, `aclk_entry_timer`:
  - Inputs: clear, enable, `one_second`.
  - Output: timeout.
  - Instantiated only under `ACLK_TIMEOUT_EN`.

## Test plan
- Reset mid-entry: key=3 held, then `reset`=1 → SHOW_TIME; all outputs 0 the following cycle; no `load_new_a`/`load_new_c` pulse.
- Digit entry: keys 1,2,3,4 each held 5 cycles, NOKEY 3 cycles between → exactly four 1-cycle `shift` pulses; `show_new_time`=1 throughout.
- Set current time:
  - Enter 1,2,3,4, then `time_button`=1.
  - Required response: `load_new_c`=`reset_count`=1 for exactly 1 cycle, then SHOW_TIME.
  - Holding `time_button` afterwards causes no further strobe.
- Set alarm time:
  - Enter 0,7,3,0, then `alarm_button` and `time_button` high together.
  - Required response: only `load_new_a` pulses; `load_new_c` stays 0.
  - Holding `alarm_button` afterwards gives SHOW_ALARM (`show_a`=1) until release.
- Timeout (`ACLK_TIMEOUT_EN`, TIMEOUT_SECS=10):
  - Enter 5, release, then 10 `one_second` pulses → SHOW_TIME one cycle after the 10th pulse, no load strobe.
  - Pressing key 6 after 9 pulses restarts the count.
- Timeout disabled: same stimulus with 30 pulses → remains in KEY_ENTRY with `show_new_time`=1.
